// File: rtl/quad_collect_pkg.sv
// Shared types for the quad collector: FSM state, slot index and slot count.
package quad_collect_pkg;

  typedef enum logic {COLLECT, FULL} qc_state_t;
  typedef logic [1:0] qc_slot_t;
  localparam int QC_SLOTS = 4;

endpackage

// File: rtl/quad_collect.sv
// Packs four serial samples into parallel operands A..D for the Add4 stage.
// Define QUAD_COLLECT_SUM_EN to add the registered self-check sum output S.
module quad_collect
  import quad_collect_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] A,
  output logic [n-1:0] B,
  output logic [n-1:0] C,
  output logic [n-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef QUAD_COLLECT_SUM_EN
  output logic [n+1:0] S,
`endif
  output logic [2:0]   fill
);

  qc_state_t    state_q, state_d;
  qc_slot_t     idx_q, idx_d;
  logic [2:0]   fill_q, fill_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;
  logic [n-1:0] slot_q [QC_SLOTS];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    accept      = 1'b0;
    if (clear) begin
      // A flush drops any sample offered this cycle; slot contents are kept.
      state_d     = COLLECT;
      idx_d       = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid && in_ready_q) begin
            accept = 1'b1;
            idx_d  = idx_q + 2'd1;
            fill_d = fill_q + 3'd1;
            if (idx_q == 2'd3) begin
              state_d     = FULL;
              out_valid_d = 1'b1;
              in_ready_d  = 1'b0;
            end
          end
        end
        FULL: begin
          if (out_valid_q && out_ready) begin
            state_d     = COLLECT;
            idx_d       = '0;
            fill_d      = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < QC_SLOTS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          slot_q[gi] <= '0;
        end else if (accept && (idx_q == qc_slot_t'(gi))) begin
          slot_q[gi] <= in_data;
        end
      end
    end
  endgenerate

`ifdef QUAD_COLLECT_SUM_EN
  // The fourth sample is still on in_data when the sum is captured.
  logic [n+1:0] s_q;
  logic [n+1:0] s_d;
  assign s_d = (n+2)'(slot_q[0]) + (n+2)'(slot_q[1]) + (n+2)'(slot_q[2]) + (n+2)'(in_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0;
    end else if (accept && (idx_q == 2'd3)) begin
      s_q <= s_d;
    end
  end

  assign S = s_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign fill      = fill_q;
  assign A         = slot_q[0];
  assign B         = slot_q[1];
  assign C         = slot_q[2];
  assign D         = slot_q[3];

endmodule

// File: tb/tb_quad_collect.sv
// Directed table-driven bench for quad_collect (n=4), with hand-written
// backpressure and reset-while-full sequences.
module tb_quad_collect;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B, C, D;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   fill;
`ifdef QUAD_COLLECT_SUM_EN
  logic [N+1:0] S;
`endif

  quad_collect #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef QUAD_COLLECT_SUM_EN
    .S         (S),
`endif
    .fill      (fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cl;
    logic       iv;
    logic [3:0] din;
    logic       ordy;
    logic       ov;
    logic [2:0] fl;
    logic       ir;
    logic [3:0] ea, eb, ec, ed;
    logic [5:0] es;
  } vec_t;

  vec_t vecs [27];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [2:0] fl, input logic ir,
                           input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ec,
                           input logic [3:0] ed, input logic [5:0] es);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".fill"}, 32'(fill), 32'(fl));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, ".A"}, 32'(A), 32'(ea));
    chk({tag, ".B"}, 32'(B), 32'(eb));
    chk({tag, ".C"}, 32'(C), 32'(ec));
    chk({tag, ".D"}, 32'(D), 32'(ed));
`ifdef QUAD_COLLECT_SUM_EN
    chk({tag, ".S"}, 32'(S), 32'(es));
`else
    if (es > 6'd60) $display("note %s unexpected sum table entry", tag);
`endif
    $display("%s ov=%0b fill=%0d ir=%0b A=%0d B=%0d C=%0d D=%0d", tag, out_valid, fill, in_ready, A, B, C, D);
  endtask

  task automatic drive(input logic cl, input logic iv, input logic [3:0] din, input logic ordy);
    clear     = cl;
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input int i);
    drive(vecs[i].cl, vecs[i].iv, vecs[i].din, vecs[i].ordy);
    check_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].fl, vecs[i].ir,
              vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed, vecs[i].es);
  endtask

  function automatic vec_t mk(input logic cl, input logic iv, input logic [3:0] din, input logic ordy,
                              input logic ov, input logic [2:0] fl, input logic ir,
                              input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ec,
                              input logic [3:0] ed, input logic [5:0] es);
    vec_t v;
    v.cl = cl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ov = ov; v.fl = fl; v.ir = ir;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed; v.es = es;
    return v;
  endfunction

  initial begin
    //             cl iv din   or  ov fl ir  A    B    C    D    S
    // basic quad 5,2,12,15
    vecs[0]  = mk(0, 1, 4'h5, 0,  0, 1, 1, 5,   0,   0,   0,   0);
    vecs[1]  = mk(0, 1, 4'h2, 0,  0, 2, 1, 5,   2,   0,   0,   0);
    vecs[2]  = mk(0, 1, 4'hC, 0,  0, 3, 1, 5,   2,  12,   0,   0);
    vecs[3]  = mk(0, 1, 4'hF, 0,  1, 4, 0, 5,   2,  12,  15,  34);
    // transfer, then out_ready with nothing valid
    vecs[4]  = mk(0, 0, 4'h0, 1,  0, 0, 1, 5,   2,  12,  15,  34);
    vecs[5]  = mk(0, 0, 4'h0, 1,  0, 0, 1, 5,   2,  12,  15,  34);
    // gapped input of 4'hF
    vecs[6]  = mk(0, 1, 4'hF, 0,  0, 1, 1, 15,  2,  12,  15,  34);
    vecs[7]  = mk(0, 0, 4'h3, 0,  0, 1, 1, 15,  2,  12,  15,  34);
    vecs[8]  = mk(0, 1, 4'hF, 0,  0, 2, 1, 15, 15,  12,  15,  34);
    vecs[9]  = mk(0, 0, 4'h3, 0,  0, 2, 1, 15, 15,  12,  15,  34);
    vecs[10] = mk(0, 1, 4'hF, 0,  0, 3, 1, 15, 15,  15,  15,  34);
    vecs[11] = mk(0, 0, 4'h3, 0,  0, 3, 1, 15, 15,  15,  15,  34);
    vecs[12] = mk(0, 1, 4'hF, 0,  1, 4, 0, 15, 15,  15,  15,  60);
    // FULL ignores in_valid; transfer drops the offered sample
    vecs[13] = mk(0, 1, 4'h9, 0,  1, 4, 0, 15, 15,  15,  15,  60);
    vecs[14] = mk(0, 1, 4'h9, 1,  0, 0, 1, 15, 15,  15,  15,  60);
    // clear mid-quad
    vecs[15] = mk(0, 1, 4'h1, 0,  0, 1, 1, 1,  15,  15,  15,  60);
    vecs[16] = mk(0, 1, 4'h2, 0,  0, 2, 1, 1,   2,  15,  15,  60);
    vecs[17] = mk(1, 1, 4'h9, 0,  0, 0, 1, 1,   2,  15,  15,  60);
    vecs[18] = mk(0, 1, 4'h3, 0,  0, 1, 1, 3,   2,  15,  15,  60);
    vecs[19] = mk(0, 1, 4'h4, 0,  0, 2, 1, 3,   4,  15,  15,  60);
    vecs[20] = mk(0, 1, 4'h5, 0,  0, 3, 1, 3,   4,   5,  15,  60);
    vecs[21] = mk(0, 1, 4'h6, 0,  1, 4, 0, 3,   4,   5,   6,  18);
    // clear while FULL, even with out_ready high; then refill starts at A
    vecs[22] = mk(1, 1, 4'h8, 1,  0, 0, 1, 3,   4,   5,   6,  18);
    vecs[23] = mk(0, 1, 4'h8, 0,  0, 1, 1, 8,   4,   5,   6,  18);
    vecs[24] = mk(0, 1, 4'h7, 0,  0, 2, 1, 8,   7,   5,   6,  18);
    vecs[25] = mk(0, 1, 4'h1, 0,  0, 3, 1, 8,   7,   1,   6,  18);
    vecs[26] = mk(0, 1, 4'h2, 0,  1, 4, 0, 8,   7,   1,   2,  18);

    rst_n = 1'b0; clear = 0; in_valid = 0; in_data = 0; out_ready = 0;
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", 0, 0, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) apply_row(i);

    // backpressure: quad must hold for 10 cycles while samples are offered
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 4'h7, 0);
      check_all($sformatf("hold%0d", k), 1, 4, 0, 5, 2, 12, 15, 34);
    end

    for (int i = 4; i < 27; i++) apply_row(i);

    // reset while FULL wipes everything, S included
    drive(0, 0, 4'h0, 0);
    check_all("full_before_rst", 1, 4, 0, 8, 7, 1, 2, 18);
    rst_n = 1'b0;
    drive(0, 1, 4'hA, 1);
    check_all("rst_full", 0, 0, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // all-zero quad after reset
    for (int k = 0; k < 4; k++) drive(0, 1, 4'h0, 0);
    check_all("zero_quad", 1, 4, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
